// File: rtl/barrel_pkg.sv
// barrel_pkg: shared constants and helpers for the barrel-threaded fetch stage.
//   - Default widths, thread count and per-thread start addresses.
//   - bits_threads(): thread-ID width for a given thread count.
//   - PC_INCR: sequential PC step (one 32-bit instruction).
package barrel_pkg;

  localparam int unsigned DEF_ADDRESS_WIDTH = 32;
  localparam int unsigned DEF_NUM_THREADS   = 4;
  localparam logic [31:0] DEF_RESET_PC      = 32'h0000_0000;
  localparam logic [31:0] DEF_THREAD_STRIDE = 32'h0000_0400;
  localparam int unsigned PC_INCR           = 4;

  function automatic int unsigned bits_threads(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/barrel_fetch_thread_pc_file.sv
// thread_pc_file: one architectural PC per hardware thread.
//   clk, rst_n   : clock, asynchronous active-low reset (thread t -> RESET_PC + t*THREAD_STRIDE)
//   rd_sel/rd_pc : combinational read port
//   adv_*        : sequential-advance write port
//   redir_*      : redirect write port, wins over adv_* on the same entry
module thread_pc_file
  import barrel_pkg::*;
#(
  parameter int unsigned              ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
  parameter int unsigned              NUM_THREADS   = DEF_NUM_THREADS,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = ADDRESS_WIDTH'(DEF_RESET_PC),
  parameter logic [ADDRESS_WIDTH-1:0] THREAD_STRIDE = ADDRESS_WIDTH'(DEF_THREAD_STRIDE)
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [bits_threads(NUM_THREADS)-1:0]   rd_sel,
  output logic [ADDRESS_WIDTH-1:0]               rd_pc,
  input  logic                                   adv_en,
  input  logic [bits_threads(NUM_THREADS)-1:0]   adv_sel,
  input  logic [ADDRESS_WIDTH-1:0]               adv_pc,
  input  logic                                   redir_en,
  input  logic [bits_threads(NUM_THREADS)-1:0]   redir_tid,
  input  logic [ADDRESS_WIDTH-1:0]               redir_pc
);

  localparam int unsigned TW = bits_threads(NUM_THREADS);

  logic [ADDRESS_WIDTH-1:0] pc_q [NUM_THREADS];
  logic [ADDRESS_WIDTH-1:0] pc_d [NUM_THREADS];

  assign rd_pc = pc_q[rd_sel];

  always_comb begin
    for (int unsigned t = 0; t < NUM_THREADS; t++) begin
      pc_d[t] = pc_q[t];
      if (redir_en && (redir_tid == TW'(t))) begin
        pc_d[t] = redir_pc;
      end else if (adv_en && (adv_sel == TW'(t))) begin
        pc_d[t] = adv_pc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned t = 0; t < NUM_THREADS; t++) begin
        pc_q[t] <= RESET_PC + ADDRESS_WIDTH'(t) * THREAD_STRIDE;
      end
    end else begin
      for (int unsigned t = 0; t < NUM_THREADS; t++) begin
        pc_q[t] <= pc_d[t];
      end
    end
  end

endmodule

// File: rtl/barrel_fetch.sv
// barrel_fetch: round-robin fetch stage of a barrel-threaded RISC-V pipeline.
//   clk, rst_n          : clock, asynchronous active-low reset
//   stall_f             : hold slot counter, fetch outputs and PC advance
//   thread_en           : per-thread run enable (disabled slot issues a bubble)
//   pc_src_e/pc_target_e/tid_e : resolved redirect from execute
//   pc_f, pc_plus4_f, tid_f, valid_f : registered fetch outputs
module barrel_fetch
  import barrel_pkg::*;
#(
  parameter int unsigned              ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
  parameter int unsigned              NUM_THREADS   = DEF_NUM_THREADS,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = ADDRESS_WIDTH'(DEF_RESET_PC),
  parameter logic [ADDRESS_WIDTH-1:0] THREAD_STRIDE = ADDRESS_WIDTH'(DEF_THREAD_STRIDE)
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 stall_f,
  input  logic [NUM_THREADS-1:0]               thread_en,
  input  logic                                 pc_src_e,
  input  logic [ADDRESS_WIDTH-1:0]             pc_target_e,
  input  logic [bits_threads(NUM_THREADS)-1:0] tid_e,
  output logic [ADDRESS_WIDTH-1:0]             pc_f,
  output logic [ADDRESS_WIDTH-1:0]             pc_plus4_f,
  output logic [bits_threads(NUM_THREADS)-1:0] tid_f,
  output logic                                 valid_f
);

  localparam int unsigned TW = bits_threads(NUM_THREADS);

  logic [TW-1:0]            slot_q, slot_d;
  logic [ADDRESS_WIDTH-1:0] pc_f_q, pc_f_d;
  logic [ADDRESS_WIDTH-1:0] pc_plus4_f_q, pc_plus4_f_d;
  logic [TW-1:0]            tid_f_q, tid_f_d;
  logic                     valid_f_q, valid_f_d;

  logic [ADDRESS_WIDTH-1:0] rd_pc;
  logic [ADDRESS_WIDTH-1:0] fpc;
  logic [ADDRESS_WIDTH-1:0] fpc_plus4;
  logic                     bypass;
  logic                     adv_en;
  logic [ADDRESS_WIDTH-1:0] adv_pc;
  logic                     redir_en;

  thread_pc_file #(
    .ADDRESS_WIDTH (ADDRESS_WIDTH),
    .NUM_THREADS   (NUM_THREADS),
    .RESET_PC      (RESET_PC),
    .THREAD_STRIDE (THREAD_STRIDE)
  ) u_pc_file (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_sel    (slot_q),
    .rd_pc     (rd_pc),
    .adv_en    (adv_en),
    .adv_sel   (slot_q),
    .adv_pc    (adv_pc),
    .redir_en  (redir_en),
    .redir_tid (tid_e),
    .redir_pc  (pc_target_e)
  );

  always_comb begin
    slot_d       = slot_q;
    pc_f_d       = pc_f_q;
    pc_plus4_f_d = pc_plus4_f_q;
    tid_f_d      = tid_f_q;
    valid_f_d    = valid_f_q;

    // A redirect aimed at the thread being fetched this cycle is folded into
    // the fetch PC; its separate write is then suppressed so the advanced
    // value (target+4) lands instead of the raw target.
    bypass    = pc_src_e && (tid_e == slot_q) && !stall_f;
    fpc       = bypass ? pc_target_e : rd_pc;
    fpc_plus4 = fpc + ADDRESS_WIDTH'(PC_INCR);

    adv_en   = !stall_f;
    adv_pc   = thread_en[slot_q] ? fpc_plus4 : fpc;
    redir_en = pc_src_e && !bypass;

    if (!stall_f) begin
      slot_d       = slot_q + 1'b1;
      pc_f_d       = fpc;
      pc_plus4_f_d = fpc_plus4;
      tid_f_d      = slot_q;
      valid_f_d    = thread_en[slot_q];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q       <= '0;
      pc_f_q       <= '0;
      pc_plus4_f_q <= '0;
      tid_f_q      <= '0;
      valid_f_q    <= 1'b0;
    end else begin
      slot_q       <= slot_d;
      pc_f_q       <= pc_f_d;
      pc_plus4_f_q <= pc_plus4_f_d;
      tid_f_q      <= tid_f_d;
      valid_f_q    <= valid_f_d;
    end
  end

  assign pc_f       = pc_f_q;
  assign pc_plus4_f = pc_plus4_f_q;
  assign tid_f      = tid_f_q;
  assign valid_f    = valid_f_q;

endmodule

// File: tb/tb_barrel_fetch.sv
module tb_barrel_fetch;

  logic        clk;
  logic        rst_n;
  logic        stall_f;
  logic [3:0]  thread_en;
  logic        pc_src_e;
  logic [31:0] pc_target_e;
  logic [1:0]  tid_e;
  logic [31:0] pc_f;
  logic [31:0] pc_plus4_f;
  logic [1:0]  tid_f;
  logic        valid_f;

  int unsigned total;
  int unsigned bad;

  barrel_fetch #(
    .ADDRESS_WIDTH (32),
    .NUM_THREADS   (4),
    .RESET_PC      (32'h0000_0000),
    .THREAD_STRIDE (32'h0000_0400)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall_f     (stall_f),
    .thread_en   (thread_en),
    .pc_src_e    (pc_src_e),
    .pc_target_e (pc_target_e),
    .tid_e       (tid_e),
    .pc_f        (pc_f),
    .pc_plus4_f  (pc_plus4_f),
    .tid_f       (tid_f),
    .valid_f     (valid_f)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [1:0] tid,
                            input logic [31:0] pc, input logic vld);
    check_eq({tag, ".tid"},    {30'd0, tid_f},   {30'd0, tid});
    check_eq({tag, ".pc"},     pc_f,             pc);
    check_eq({tag, ".pc4"},    pc_plus4_f,       pc + 32'd4);
    check_eq({tag, ".valid"},  {31'd0, valid_f}, {31'd0, vld});
  endtask

  task automatic expect_zero(input string tag);
    check_eq({tag, ".tid"},   {30'd0, tid_f},   32'd0);
    check_eq({tag, ".pc"},    pc_f,             32'd0);
    check_eq({tag, ".pc4"},   pc_plus4_f,       32'd0);
    check_eq({tag, ".valid"}, {31'd0, valid_f}, 32'd0);
  endtask

  task automatic do_reset(input logic [3:0] en);
    rst_n     = 1'b0;
    thread_en = en;
    #1;
    expect_zero("rst");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [31:0] seq_pc [8];
  logic [31:0] dis_pc [8];
  logic        dis_v  [8];

  initial begin
    total       = 0;
    bad         = 0;
    rst_n       = 1'b0;
    stall_f     = 1'b0;
    thread_en   = 4'b1111;
    pc_src_e    = 1'b0;
    pc_target_e = 32'd0;
    tid_e       = 2'd0;

    // all threads enabled from reset
    seq_pc = '{32'h000, 32'h400, 32'h800, 32'hC00, 32'h004, 32'h404, 32'h804, 32'hC04};
    #2;
    expect_zero("por");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      expect_out($sformatf("seq%0d", i), 2'(i % 4), seq_pc[i], 1'b1);
    end

    // thread 2 disabled: bubbles at a frozen PC
    do_reset(4'b1011);
    dis_pc = '{32'h000, 32'h400, 32'h800, 32'hC00, 32'h004, 32'h404, 32'h800, 32'hC04};
    dis_v  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 8; i++) begin
      tick();
      expect_out($sformatf("dis%0d", i), 2'(i % 4), dis_pc[i], dis_v[i]);
    end
    // PCs now: t0=0x008 t1=0x408 t2=0x800 t3=0xC08, next slot 0

    // redirect thread 3 while slot 1 is selected
    thread_en = 4'b1111;
    tick();  expect_out("r3a", 2'd0, 32'h008, 1'b1);
    pc_src_e = 1'b1; tid_e = 2'd3; pc_target_e = 32'h2000;
    tick();  expect_out("r3b", 2'd1, 32'h408, 1'b1);
    pc_src_e = 1'b0;
    tick();  expect_out("r3c", 2'd2, 32'h800, 1'b1);
    tick();  expect_out("r3d", 2'd3, 32'h2000, 1'b1);
    tick();  expect_out("r3e", 2'd0, 32'h00C, 1'b1);
    tick();  expect_out("r3f", 2'd1, 32'h40C, 1'b1);
    tick();  expect_out("r3g", 2'd2, 32'h804, 1'b1);
    tick();  expect_out("r3h", 2'd3, 32'h2004, 1'b1);
    // PCs: t0=0x010 t1=0x410 t2=0x808 t3=0x2008, next slot 0

    // redirect thread 0 in its own selection cycle (bypass)
    pc_src_e = 1'b1; tid_e = 2'd0; pc_target_e = 32'h3000;
    tick();  expect_out("byp0", 2'd0, 32'h3000, 1'b1);
    pc_src_e = 1'b0;
    tick();  expect_out("byp1", 2'd1, 32'h410, 1'b1);
    tick();  expect_out("byp2", 2'd2, 32'h808, 1'b1);
    tick();  expect_out("byp3", 2'd3, 32'h2008, 1'b1);
    tick();  expect_out("byp4", 2'd0, 32'h3004, 1'b1);
    // PCs: t0=0x3008 t1=0x414 t2=0x80C t3=0x200C, next slot 1

    // 3-cycle stall with a redirect to thread 2 mid-stall
    stall_f = 1'b1;
    tick();  expect_out("stl0", 2'd0, 32'h3004, 1'b1);
    pc_src_e = 1'b1; tid_e = 2'd2; pc_target_e = 32'h5000;
    tick();  expect_out("stl1", 2'd0, 32'h3004, 1'b1);
    pc_src_e = 1'b0;
    tick();  expect_out("stl2", 2'd0, 32'h3004, 1'b1);
    stall_f = 1'b0;
    tick();  expect_out("stl3", 2'd1, 32'h414, 1'b1);
    tick();  expect_out("stl4", 2'd2, 32'h5000, 1'b1);
    // next slot 3 (t3=0x200C)

    // stalled redirect aimed at the held slot must not be lost
    stall_f = 1'b1;
    pc_src_e = 1'b1; tid_e = 2'd3; pc_target_e = 32'h6000;
    tick();  expect_out("sts0", 2'd2, 32'h5000, 1'b1);
    pc_src_e = 1'b0; stall_f = 1'b0;
    tick();  expect_out("sts1", 2'd3, 32'h6000, 1'b1);
    tick();  expect_out("sts2", 2'd0, 32'h3008, 1'b1);

    // asynchronous reset mid-rotation, between clock edges
    #1;
    rst_n = 1'b0;
    #1;
    expect_zero("arst");
    @(negedge clk);
    rst_n = 1'b1;
    tick();  expect_out("post0", 2'd0, 32'h000, 1'b1);
    tick();  expect_out("post1", 2'd1, 32'h400, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/barrel_fetch.md
Name: barrel_fetch

Overview:
- Fetch stage of the barrel (fine-grained multithreaded) RISC-V pipeline.
- Holds one PC per hardware thread and issues one fetch per cycle in strict round-robin slot order.
- Presents the registered PC, PC+4 and thread ID to instruction memory and the decode register.
- Consumes the execute stage's resolved redirect (pc_src_e, pc_target_e, tid_e) to update the owning thread's PC.

Parameters:
- ADDRESS_WIDTH, 32, PC width in bits.
- NUM_THREADS, 4, hardware thread count; must be a power of two, at least 2.
- RESET_PC, 32'h0000_0000, start PC of thread 0.
- THREAD_STRIDE, 32'h0000_0400, start-address spacing; thread t resets to RESET_PC + t*THREAD_STRIDE.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- stall_f  in  1  hold fetch outputs, slot counter and sequential PC advance.
- thread_en  in  NUM_THREADS  per-thread run enable; bit t enables thread t.
- pc_src_e  in  1  redirect valid from execute.
- pc_target_e  in  ADDRESS_WIDTH  redirect target PC.
- tid_e  in  BITS_THREADS  thread owning the redirect.
- pc_f  out  ADDRESS_WIDTH  fetch PC to instruction memory.
- pc_plus4_f  out  ADDRESS_WIDTH  pc_f + 4.
- tid_f  out  BITS_THREADS  thread ID of the fetch.
- valid_f  out  1  fetch slot carries a real instruction.

Behaviour:
- BITS_THREADS = $clog2(NUM_THREADS).
- State:
  - slot counter, BITS_THREADS bits.
  - pc_q[NUM_THREADS] array.
  - output registers.
- Reset (asynchronous assert, synchronous release on clk):
  - slot = 0, pc_q[t] = RESET_PC + t*THREAD_STRIDE.
  - pc_f = 0, pc_plus4_f = 0, tid_f = 0, valid_f = 0.
- Per non-stalled cycle, with sel = slot:
  - slot <= slot + 1. Wraps from NUM_THREADS-1 to 0 naturally; no skipping of disabled threads, so the fixed barrel spacing is preserved.
  - tid_f <= sel; valid_f <= thread_en[sel].
  - pc_f <= fpc; pc_plus4_f <= fpc + 4 (mod 2^ADDRESS_WIDTH).
  - fpc = pc_target_e if (pc_src_e && tid_e == sel), else pc_q[sel].
  - If thread_en[sel] = 1: pc_q[sel] <= fpc + 4.
  - If thread_en[sel] = 0: bubble. pc_q[sel] <= fpc, so a redirect is kept and the PC does not advance. pc_f still shows fpc.
- Redirect to a thread other than sel: pc_q[tid_e] <= pc_target_e that cycle, regardless of stall_f.
- Redirect to sel while not stalled: bypassed as above. The redirect wins over the stale PC and is never lost.
- Stall (stall_f = 1):
  - slot, pc_f, pc_plus4_f, tid_f and valid_f hold.
  - No PC advances.
  - A redirect still writes pc_q[tid_e] <= pc_target_e, including when tid_e == slot.
- Latency: selection to outputs is 1 cycle. A redirect affects the first fetch of tid_e whose selection cycle is at or after the redirect cycle.
- thread_en changes take effect at the next selection of that thread. No state is cleared.
- Redirect targets are not alignment-checked; bits [1:0] pass through unchanged.
- Wrong-path squash of in-flight instructions is not this block's job. With NUM_THREADS at least the fetch-to-execute depth, none exist.
- No combinational path from inputs to outputs.

Decomposition:
- Shared package barrel_pkg:
  - BITS_THREADS function/constant.
  - Default ADDRESS_WIDTH and NUM_THREADS.
  - PC increment constant 4.
  - Default RESET_PC and THREAD_STRIDE.
- One sub-module, thread_pc_file:
  - NUM_THREADS x ADDRESS_WIDTH register array with async active-low reset to per-thread start PCs.
  - One combinational read port (sel).
  - One write port with redirect priority over the sequential advance.
- Slot counter, bypass mux and output registers live in barrel_fetch.

Test Plan:
- Reset, then release with all thread_en = 1 and defaults, 8 cycles:
  - tid_f sequence is 0,1,2,3,0,1,2,3.
  - pc_f sequence is 0x000, 0x400, 0x800, 0xC00, 0x004, 0x404, 0x804, 0xC04.
  - valid_f = 1 throughout.
- thread_en = 4'b1011:
  - Thread 2 slots show valid_f = 0 and pc_f = 0x800 each rotation.
  - Thread 2 PC stays 0x800; the other threads advance by 4 per rotation.
- pc_src_e = 1, tid_e = 3, pc_target_e = 0x2000 while slot = 1:
  - Next thread-3 fetch has pc_f = 0x2000, pc_plus4_f = 0x2004.
  - The following thread-3 fetch has pc_f = 0x2004.
- Redirect tid_e = 0, pc_target_e = 0x3000 in the same cycle thread 0 is selected:
  - Next cycle pc_f = 0x3000 (bypass).
  - Thread 0's subsequent fetch has pc_f = 0x3004.
- stall_f = 1 for 3 cycles with a redirect tid_e = 2, pc_target_e = 0x5000 mid-stall:
  - All outputs hold for those 3 cycles.
  - After release, rotation resumes at the held slot + 1.
  - Thread 2's next fetch is 0x5000.
- Assert rst_n low asynchronously mid-rotation:
  - Outputs go to 0 and valid_f to 0 immediately, without a clock edge.
  - After release, the sequence restarts at tid 0, pc_f = 0x000.
